// File: rtl/vector_mem_port.sv
// ---------------------------------------------------------------------------
// vector_mem_port
//
// Memory-side partner of the vector register file's load/store interface.
// Owns a word-wide data memory and moves whole vectors between it and the
// register file, one memory word per clock.
//
//   Vector load  : read BEATS consecutive words into an assembly buffer, then
//                  present the full vector on load_data with a one-cycle
//                  load strobe so the register file captures it.
//   Vector store : pulse store to ask the register file for a vector, capture
//                  the returned store_data one cycle later, then write it back
//                  to memory as BEATS consecutive words.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high; clears FSM, counters, outputs
//   cmd_valid      command strobe (only looked at while idle)
//   cmd_load       command is a vector load  (memory -> register)
//   cmd_store      command is a vector store (register -> memory)
//   cmd_addr       base word address of the transfer
//   cmd_reg        register index for the transfer
//   cmd_ready      high while idle and able to take a command
//   cmd_err        one-cycle pulse after a command with a bad type field
//   done           one-cycle pulse when a transfer completes
//   load           one-cycle write strobe to the register file
//   load_addr_reg  register index that goes with load
//   load_data      assembled vector; holds until the next load delivery
//   store          one-cycle read request to the register file
//   store_addr_reg register index that goes with store
//   store_data     vector returned by the register file
//   host_we        backdoor word write, honoured only while idle
//   host_addr      backdoor address
//   host_wdata     backdoor write data
//   host_rdata     combinational read of mem[host_addr]
//
// Word 0 of a vector (bits WORD-1:0) lives at the base address, word i at
// base+i.  Addresses wrap modulo DEPTH without complaint.
// ---------------------------------------------------------------------------
module vector_mem_port #(
    parameter int VLEN   = 512,
    parameter int WORD   = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cmd_valid,
    input  logic              cmd_load,
    input  logic              cmd_store,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [1:0]        cmd_reg,
    output logic              cmd_ready,
    output logic              cmd_err,
    output logic              done,

    output logic              load,
    output logic [1:0]        load_addr_reg,
    output logic [VLEN-1:0]   load_data,

    output logic              store,
    output logic [1:0]        store_addr_reg,
    input  logic [VLEN-1:0]   store_data,

    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [WORD-1:0]   host_wdata,
    output logic [WORD-1:0]   host_rdata
);

    localparam int BEATS  = VLEN / WORD;
    localparam int BEAT_W = $clog2(BEATS);

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_OUT,
        ST_REQ,
        ST_CAP,
        ST_WR
    } state_t;

    state_t state;
    state_t state_next;

    logic [WORD-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0] base;
    logic [1:0]        reg_idx;
    logic [BEAT_W-1:0] beat;
    logic [VLEN-1:0]   vec_buf;

    logic              cmd_legal;
    logic              last_beat;
    logic [ADDR_W-1:0] beat_addr;
    logic [WORD-1:0]   beat_rdata;
    logic [WORD-1:0]   store_word;

    // A command is well formed only when exactly one type bit is set.
    // DEPTH is a power of two (2**ADDR_W), so the natural overflow of the
    // ADDR_W-bit adder gives the modulo-DEPTH wrap of the word address.
    assign cmd_legal  = cmd_load ^ cmd_store;
    assign last_beat  = (beat == BEAT_W'(BEATS - 1));
    assign beat_addr  = base + ADDR_W'(beat);
    assign beat_rdata = mem[beat_addr];
    assign store_word = vec_buf[WORD*beat +: WORD];
    assign host_rdata = mem[host_addr];

    // State register.  Reset drops straight back to IDLE from anywhere, which
    // abandons a transfer in flight: no partial load is ever delivered and a
    // store simply stops writing words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the strobes that are pure functions of the state.
    // load/store/done are decoded from the state so that asserting reset
    // clears them immediately, without waiting for a clock edge.  cmd_ready
    // is also masked by reset so nothing looks acceptable while held in reset.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        load       = 1'b0;
        store      = 1'b0;
        done       = 1'b0;

        case (state)
            IDLE: begin
                cmd_ready = ~reset;
                if (cmd_valid && cmd_legal) begin
                    state_next = cmd_load ? LD_RD : ST_REQ;
                end
            end

            LD_RD: begin
                if (last_beat) begin
                    state_next = LD_OUT;
                end
            end

            LD_OUT: begin
                load       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end

            ST_REQ: begin
                store      = 1'b1;
                state_next = ST_CAP;
            end

            ST_CAP: begin
                state_next = ST_WR;
            end

            ST_WR: begin
                if (last_beat) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Transfer datapath: command latch, beat counter, assembly buffer and the
    // registered outputs.  On the last read beat the final word goes straight
    // into load_data together with the buffered lower words, so the complete
    // vector is already stable during the LD_OUT cycle.  load_data is kept in
    // its own register because the assembly buffer is reused by stores and
    // load_data must hold its value until the next load delivery.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base           <= '0;
            reg_idx        <= '0;
            beat           <= '0;
            vec_buf        <= '0;
            load_data      <= '0;
            load_addr_reg  <= '0;
            store_addr_reg <= '0;
            cmd_err        <= 1'b0;
        end else begin
            cmd_err <= 1'b0;

            case (state)
                IDLE: begin
                    cmd_err <= cmd_valid && !cmd_legal;
                    if (cmd_valid && cmd_legal) begin
                        base    <= cmd_addr;
                        reg_idx <= cmd_reg;
                        beat    <= '0;
                        if (cmd_store) begin
                            store_addr_reg <= cmd_reg;
                        end
                    end
                end

                LD_RD: begin
                    vec_buf[WORD*beat +: WORD] <= beat_rdata;
                    beat                       <= beat + 1'b1;
                    if (last_beat) begin
                        load_data     <= {beat_rdata, vec_buf[VLEN-WORD-1:0]};
                        load_addr_reg <= reg_idx;
                    end
                end

                ST_CAP: begin
                    vec_buf <= store_data;
                    beat    <= '0;
                end

                ST_WR: begin
                    beat <= beat + 1'b1;
                end

                default: begin
                end
            endcase
        end
    end

    // Data memory.  Not reset.  The backdoor port and the store engine never
    // compete because one is only active in IDLE and the other only in ST_WR.
    // Writes are suppressed while reset is held so an abandoned store cannot
    // land one more word on the edge that reset arrives.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == IDLE && host_we) begin
                mem[host_addr] <= host_wdata;
            end else if (state == ST_WR) begin
                mem[beat_addr] <= store_word;
            end
        end
    end

endmodule

// File: tb/tb_vector_mem_port.sv
// ---------------------------------------------------------------------------
// tb_vector_mem_port
//
// Drives vector loads, stores, illegal commands, wrap-around addresses and a
// mid-store reset into vector_mem_port.  A plain array mirrors the memory and
// a small register-file model answers store requests; expected vectors are
// built from the array word by word.
// ---------------------------------------------------------------------------
module tb_vector_mem_port;

    localparam int VLEN   = 512;
    localparam int WORD   = 32;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;
    localparam int BEATS  = VLEN / WORD;

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_load;
    logic              cmd_store;
    logic [ADDR_W-1:0] cmd_addr;
    logic [1:0]        cmd_reg;
    logic              cmd_ready;
    logic              cmd_err;
    logic              done;
    logic              load;
    logic [1:0]        load_addr_reg;
    logic [VLEN-1:0]   load_data;
    logic              store;
    logic [1:0]        store_addr_reg;
    logic [VLEN-1:0]   store_data;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [WORD-1:0]   host_wdata;
    logic [WORD-1:0]   host_rdata;

    logic [WORD-1:0]   mem_model [DEPTH];
    logic [VLEN-1:0]   rf [4];
    int                vectors     = 0;
    int                miscompares = 0;
    int                store_pulses = 0;

    vector_mem_port #(
        .VLEN   (VLEN),
        .WORD   (WORD),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_load       (cmd_load),
        .cmd_store      (cmd_store),
        .cmd_addr       (cmd_addr),
        .cmd_reg        (cmd_reg),
        .cmd_ready      (cmd_ready),
        .cmd_err        (cmd_err),
        .done           (done),
        .load           (load),
        .load_addr_reg  (load_addr_reg),
        .load_data      (load_data),
        .store          (store),
        .store_addr_reg (store_addr_reg),
        .store_data     (store_data),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_rdata     (host_rdata)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: a store request is answered with the requested
    // register's contents, registered on the closing edge.  Also counts store
    // pulses so stray requests can be detected.
    always @(posedge clk) begin
        if (store) begin
            store_data   <= rf[store_addr_reg];
            store_pulses <= store_pulses + 1;
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [VLEN-1:0] got,
                               input logic [VLEN-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Present one command for one edge, optionally with a same-cycle host write.
    task automatic applyStimulus(input logic ld, input logic st, input int addr,
                                 input logic [1:0] r, input logic hw,
                                 input int haddr, input logic [WORD-1:0] hdata);
        cmd_valid  = 1'b1;
        cmd_load   = ld;
        cmd_store  = st;
        cmd_addr   = ADDR_W'(addr);
        cmd_reg    = r;
        host_we    = hw;
        host_addr  = ADDR_W'(haddr);
        host_wdata = hdata;
        tick;
        cmd_valid  = 1'b0;
        cmd_load   = 1'b0;
        cmd_store  = 1'b0;
        host_we    = 1'b0;
        if (hw) mem_model[haddr % DEPTH] = hdata;
    endtask

    task automatic host_write(input int addr, input logic [WORD-1:0] data);
        host_we    = 1'b1;
        host_addr  = ADDR_W'(addr);
        host_wdata = data;
        tick;
        host_we    = 1'b0;
        mem_model[addr % DEPTH] = data;
    endtask

    function automatic logic [VLEN-1:0] model_vec(input int addr);
        logic [VLEN-1:0] v;
        for (int i = 0; i < BEATS; i++) v[WORD*i +: WORD] = mem_model[(addr + i) % DEPTH];
        return v;
    endfunction

    task automatic check_mem(input int addr, input string tag);
        logic [WORD-1:0] exp;
        for (int i = 0; i < BEATS; i++) begin
            host_addr = ADDR_W'((addr + i) % DEPTH);
            exp = mem_model[(addr + i) % DEPTH];
            #1;
            checkOutput(tag, host_rdata, exp);
        end
    endtask

    // Vector load.  With noise set, a legal store command and a host write to
    // a word inside the range being read are held high mid-transfer; both
    // must be ignored.
    task automatic do_load(input int addr, input logic [1:0] r, input bit noise,
                           input bit hw, input int haddr, input logic [WORD-1:0] hdata);
        logic [VLEN-1:0] exp;
        int              n;
        int              sp;
        int              naddr;
        naddr = (addr + 2) % DEPTH;
        checkOutput("ld_ready", cmd_ready, 1);
        applyStimulus(1'b1, 1'b0, addr, r, hw, haddr, hdata);
        exp = model_vec(addr);
        sp  = store_pulses;
        n   = 1;
        while (!load && n < 40) begin
            if (n == 3 && noise) begin
                cmd_valid  = 1'b1;
                cmd_store  = 1'b1;
                cmd_addr   = ADDR_W'(addr);
                host_we    = 1'b1;
                host_addr  = ADDR_W'(naddr);
                host_wdata = ~mem_model[naddr];
            end
            if (n == 5) checkOutput("ld_busy", cmd_ready, 0);
            if (n == 7) begin
                cmd_valid = 1'b0;
                cmd_store = 1'b0;
                host_we   = 1'b0;
            end
            tick;
            n++;
        end
        cmd_valid = 1'b0;
        cmd_store = 1'b0;
        host_we   = 1'b0;
        checkOutput("ld_latency", n, 17);
        checkOutput("ld_done", done, 1);
        checkOutput("ld_reg", load_addr_reg, r);
        checkOutput("ld_data", load_data, exp);
        tick;
        checkOutput("ld_pulse", load, 0);
        checkOutput("ld_done_pulse", done, 0);
        checkOutput("ld_hold", load_data, exp);
        if (noise) begin
            checkOutput("ld_ignore_cmd", store_pulses, sp);
            host_addr = ADDR_W'(naddr);
            #1;
            checkOutput("ld_ignore_host", host_rdata, mem_model[naddr]);
        end
    endtask

    // Vector store from register r; updates the memory model on completion.
    task automatic do_store(input int addr, input logic [1:0] r);
        int n;
        checkOutput("st_ready", cmd_ready, 1);
        applyStimulus(1'b0, 1'b1, addr, r, 1'b0, 0, '0);
        checkOutput("st_req", store, 1);
        checkOutput("st_reg", store_addr_reg, r);
        n = 1;
        while (!done && n < 40) begin
            tick;
            n++;
        end
        checkOutput("st_latency", n, 18);
        for (int i = 0; i < BEATS; i++) mem_model[(addr + i) % DEPTH] = rf[r][WORD*i +: WORD];
        tick;
        checkOutput("st_done_pulse", done, 0);
    endtask

    task automatic fill_reg(input logic [1:0] r);
        for (int i = 0; i < BEATS; i++) rf[r][WORD*i +: WORD] = $urandom;
    endtask

    initial begin
        logic [VLEN-1:0] v;
        logic [WORD-1:0] w;
        int              a;
        int              op;
        logic [1:0]      r;

        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_load   = 1'b0;
        cmd_store  = 1'b0;
        cmd_addr   = '0;
        cmd_reg    = '0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        for (int i = 0; i < 4; i++) rf[i] = '0;

        // Reset state
        tick;
        tick;
        checkOutput("rst_err", cmd_err, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_load", load, 0);
        checkOutput("rst_store", store, 0);
        checkOutput("rst_ld_reg", load_addr_reg, 0);
        checkOutput("rst_st_reg", store_addr_reg, 0);
        checkOutput("rst_ld_data", load_data, 0);
        reset = 1'b0;
        #1;
        checkOutput("rst_ready", cmd_ready, 1);

        // Give every memory word a known value
        for (int i = 0; i < DEPTH; i++) host_write(i, $urandom);

        // Directed load
        for (int i = 0; i < BEATS; i++) host_write(100 + i, 32'hA000_0000 + i);
        do_load(100, 2'd2, 1'b0, 1'b0, 0, '0);
        for (int i = 0; i < BEATS; i++) v[WORD*i +: WORD] = 32'hA000_0000 + i;
        checkOutput("ld_const", load_data, v);

        // Directed store
        for (int i = 0; i < BEATS; i++) rf[1][WORD*i +: WORD] = 32'h5A5A_0000 + i;
        do_store(200, 2'd1);
        for (int i = 0; i < BEATS; i++) begin
            host_addr = ADDR_W'(200 + i);
            w = 32'h5A5A_0000 + i;
            #1;
            checkOutput("st_const", host_rdata, w);
        end

        // Wrap-around store and load
        fill_reg(2'd2);
        do_store(1016, 2'd2);
        check_mem(1016, "wrap_mem");
        host_addr = ADDR_W'(0);
        w = rf[2][WORD*8 +: WORD];
        #1;
        checkOutput("wrap_low", host_rdata, w);
        tick;
        do_load(1016, 2'd1, 1'b0, 1'b0, 0, '0);
        checkOutput("wrap_vec", load_data, rf[2]);

        // Illegal commands: both type bits, then neither
        applyStimulus(1'b1, 1'b1, 40, 2'd0, 1'b0, 0, '0);
        checkOutput("ill_both_err", cmd_err, 1);
        checkOutput("ill_both_ready", cmd_ready, 1);
        checkOutput("ill_both_load", load, 0);
        checkOutput("ill_both_store", store, 0);
        tick;
        checkOutput("ill_both_pulse", cmd_err, 0);
        checkOutput("ill_both_store2", store, 0);
        applyStimulus(1'b0, 1'b0, 40, 2'd0, 1'b0, 0, '0);
        checkOutput("ill_none_err", cmd_err, 1);
        checkOutput("ill_none_store", store, 0);
        tick;
        checkOutput("ill_none_pulse", cmd_err, 0);

        // Command and host write issued mid-load are ignored
        do_load(600, 2'd3, 1'b1, 1'b0, 0, '0);

        // Host write in the same cycle as an accepted load
        do_load(700, 2'd0, 1'b0, 1'b1, 705, 32'hDEAD_BEEF);

        // Reset asserted in the middle of a store
        fill_reg(2'd3);
        applyStimulus(1'b0, 1'b1, 500, 2'd3, 1'b0, 0, '0);
        repeat (8) tick;
        reset = 1'b1;
        #1;
        checkOutput("mrst_load", load, 0);
        checkOutput("mrst_store", store, 0);
        checkOutput("mrst_done", done, 0);
        checkOutput("mrst_err", cmd_err, 0);
        for (int i = 0; i < 6; i++) mem_model[500 + i] = rf[3][WORD*i +: WORD];
        tick;
        tick;
        reset = 1'b0;
        #1;
        checkOutput("mrst_ready", cmd_ready, 1);
        check_mem(500, "mrst_mem");
        tick;
        do_load(500, 2'd2, 1'b0, 1'b0, 0, '0);

        // Back-to-back store then load of the same vector
        fill_reg(2'd0);
        do_store(300, 2'd0);
        do_load(300, 2'd1, 1'b0, 1'b0, 0, '0);
        checkOutput("b2b_vec", load_data, rf[0]);

        // Randomized mix of loads, stores and same-cycle host writes
        for (int k = 0; k < 12; k++) begin
            op = $urandom_range(0, 2);
            a  = $urandom_range(0, DEPTH - 1);
            r  = 2'($urandom_range(0, 3));
            if (op == 0) begin
                do_load(a, r, 1'b0, 1'b0, 0, '0);
            end else if (op == 1) begin
                fill_reg(r);
                do_store(a, r);
                check_mem(a, "rnd_st_mem");
                tick;
            end else begin
                do_load(a, r, 1'b0, 1'b1, (a + $urandom_range(0, BEATS - 1)) % DEPTH, $urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vector_mem_port.md
Name: vector_mem_port

Overview:
- Memory-side counterpart of the vector register file's load/store interface.
- Owns a word-wide data memory. Serves 512-bit vector loads by reading 16 words and driving load/load_data/load_addr_reg into the register file.
- Serves vector stores by pulsing store/store_addr_reg, capturing the returned store_data, and writing it back as 16 sequential words.
- Sits between the vector control unit (command side) and the register file (vector side).

Parameters:
- VLEN, 512, vector width in bits.
- WORD, 32, memory word width; VLEN/WORD = BEATS = 16.
- DEPTH, 1024, memory depth in words.
- ADDR_W, 10, word address width, log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears FSM, counters and all outputs.
- cmd_valid  input  1  command strobe, sampled only in IDLE.
- cmd_load  input  1  command is a vector load (memory -> register).
- cmd_store  input  1  command is a vector store (register -> memory).
- cmd_addr  input  ADDR_W  base word address.
- cmd_reg  input  2  register index for the transfer.
- cmd_ready  output  1  high while in IDLE.
- cmd_err  output  1  one-cycle pulse when a command is rejected.
- done  output  1  one-cycle pulse when a transfer completes.
- load  output  1  one-cycle write strobe to the register file.
- load_addr_reg  output  2  register index for load.
- load_data  output  VLEN  assembled vector.
- store  output  1  one-cycle read request to the register file.
- store_addr_reg  output  2  register index for store.
- store_data  input  VLEN  vector returned by the register file.
- host_we  input  1  backdoor word write; honoured only in IDLE.
- host_addr  input  ADDR_W  backdoor address.
- host_wdata  input  WORD  backdoor write data.
- host_rdata  output  WORD  combinational read of mem[host_addr].

Behaviour:
- Reset values: cmd_ready=1 once reset is released; cmd_err=0, done=0, load=0, store=0, load_addr_reg=0, store_addr_reg=0, load_data=0; state=IDLE, beat=0. Memory contents are not reset.
- States: IDLE, LD_RD, LD_OUT, ST_REQ, ST_CAP, ST_WR.
- IDLE, cmd_valid with exactly one of cmd_load/cmd_store set: latch cmd_addr into base and cmd_reg into reg_idx, clear beat, go to LD_RD (load) or ST_REQ (store).
- IDLE, cmd_valid with both or neither type bit set: pulse cmd_err next cycle, stay in IDLE.
- cmd_valid outside IDLE: ignored, no error.
- LD_RD (16 cycles): each cycle, buf[WORD*beat +: WORD] <= mem[(base+beat) mod DEPTH], then beat++. After beat 15, go to LD_OUT.
- LD_OUT (1 cycle): load=1, load_addr_reg=reg_idx, load_data=buf, done=1, then go to IDLE.
- load_data holds its value until the next LD_OUT; load and done are 0 outside LD_OUT.
- Load latency: command accepted at edge 0; load/done high in cycle 17.
- ST_REQ (1 cycle): store=1, store_addr_reg=reg_idx. The register file registers store_data on the closing edge.
- ST_CAP (1 cycle): buf <= store_data at the closing edge.
- ST_WR (16 cycles): mem[(base+beat) mod DEPTH] <= buf[WORD*beat +: WORD], beat++. done=1 during beat 15, then go to IDLE.
- Store latency: done in cycle 18 after acceptance.
- Word order: word 0 (bits 31:0) maps to base. Address arithmetic wraps modulo DEPTH; no error on wrap.
- Register-file contract: the control unit must hold the register file's reset, random_set, write_enable and read low while load or store is high, since those inputs take priority there.
- host_we: writes mem[host_addr] only in IDLE; ignored in every other state. host_rdata is always a combinational read.
- host_we in the same IDLE cycle as an accepted command: the host write happens and the command is accepted. Load beats read the updated memory.
- Reset mid-transfer: immediate return to IDLE and all outputs cleared. Store words already written remain in memory; no partial load is delivered.
- Back-to-back: a new command may be accepted in the first IDLE cycle after done.

Test Plan:
- Load: host-write mem[100+i]=32'hA000_0000+i for i=0..15, then load to reg 2 at addr 100 -> in cycle 17 load=1, load_addr_reg=2, done=1, load_data word i = 32'hA000_0000+i; load is high for exactly one cycle.
- Store: reg 1 holds words 32'h5A5A_0000+i; store from reg 1 to addr 200 -> store=1 in cycle 1 with store_addr_reg=1, done in cycle 18, host_rdata at 200+i = 32'h5A5A_0000+i.
- Wrap: store to addr 1016 -> words 0..7 land at 1016..1023, words 8..15 land at 0..7; load from 1016 returns an identical vector.
- Illegal command: cmd_valid with cmd_load=cmd_store=1 -> cmd_err pulses one cycle, no load/store, cmd_ready stays 1. A command issued mid-load is ignored, and host_we mid-load leaves memory unchanged.
- Reset mid-store: assert reset in cycle 8 of a store -> outputs are 0 asynchronously, the first 6 words are written and the rest unchanged, and a subsequent load completes normally.
- Back-to-back: store to addr 300 immediately followed by load from 300 -> the load is accepted the cycle after done, and the returned load_data equals the stored vector.
